shift_reg_seq_ctrl: RTL and testbench

- Frame sequencer for the serial-in/parallel-out shift register (shift_reg, ports d/clk/en/rstn/out).
- Accepts a strobed serial bit stream with a start marker and gates the register's shift enable. Counts exactly MSB bits per frame, then captures the parallel word into a holding register.
- Presents the captured word on a valid/ready handshake to the downstream consumer.
- Sits between the chip-level serial input pins and any word consumer.

---
 rtl/shift_reg_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_reg_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq_ctrl.sv
// Frame sequencer for a serial-in/parallel-out shift register.
// Gates the shift enable for a start-marked, strobed bit stream. After MSB
// accepted bits it captures the register's parallel output into a holding
// word that is offered on a valid/ready handshake.
// Optional build macro SR_SEQ_PARITY_EN adds a trailing even-parity bit
// per frame and drives par_err; without it par_err is tied low.
module shift_reg_seq_ctrl #(
  parameter int unsigned MSB = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           din,
  input  logic           din_vld,
  output logic           sr_en,
  output logic           sr_d,
  input  logic [MSB-1:0] sr_out,
  output logic [MSB-1:0] word,
  output logic           word_vld,
  input  logic           word_rdy,
  output logic           busy,
  output logic           overrun,
  output logic           par_err
);

  localparam int unsigned CNT_W = $clog2(MSB + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    PARITY  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;
  logic             load;
  logic             drop;
  logic             clr_ovr;
`ifdef SR_SEQ_PARITY_EN
  logic             par_take;
  logic             par_bit;
`endif

  assign sr_d     = din;
  assign busy     = (state != IDLE);
  assign sr_en    = (state == SHIFT) && din_vld && !start;
  assign last_bit = (bit_cnt == CNT_W'(MSB - 1));

  // State and bit counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Next-state, counter and capture strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    load      = 1'b0;
    drop      = 1'b0;
    clr_ovr   = 1'b0;
`ifdef SR_SEQ_PARITY_EN
    par_take  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          clr_ovr   = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_nxt = '0;
        end else if (din_vld) begin
          cnt_nxt = bit_cnt + CNT_W'(1);
          if (last_bit) begin
`ifdef SR_SEQ_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = CAPTURE;
`endif
          end
        end
      end
`ifdef SR_SEQ_PARITY_EN
      PARITY: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else if (din_vld) begin
          state_nxt = CAPTURE;
          par_take  = 1'b1;
        end
      end
`endif
      CAPTURE: begin
        // A pending word may be replaced only if it is consumed this cycle
        load = !word_vld || word_rdy;
        drop = !load;
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Holding word, handshake valid and sticky overrun
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word     <= '0;
      word_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        word     <= sr_out;
        word_vld <= 1'b1;
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end
      if (clr_ovr) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SR_SEQ_PARITY_EN
  // Trailing parity bit and even-parity check, updated on word load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (par_take) begin
        par_bit <= din;
      end
      if (load) begin
        par_err <= (^sr_out) ^ par_bit;
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Directed bench for shift_reg_seq_ctrl (MSB=8) with a frame-level reference
// model and an attached shift register that places the oldest bit at the top.
module tb_shift_reg_seq_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         din;
  logic         din_vld;
  logic         sr_en;
  logic         sr_d;
  logic [W-1:0] sr_out;
  logic [W-1:0] word;
  logic         word_vld;
  logic         word_rdy;
  logic         busy;
  logic         overrun;
  logic         par_err;

  int total = 0;
  int bad   = 0;

  shift_reg_seq_ctrl #(.MSB(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .din      (din),
    .din_vld  (din_vld),
    .sr_en    (sr_en),
    .sr_d     (sr_d),
    .sr_out   (sr_out),
    .word     (word),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .busy     (busy),
    .overrun  (overrun),
    .par_err  (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shift register: the first bit of a frame ends up in the MSB
  always @(posedge clk or negedge rstn) begin
    if (!rstn) sr_out <= '0;
    else if (sr_en) sr_out <= {sr_out[W-2:0], sr_d};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame phases, received bits and output registers
  bit           collecting, awaiting_par, capturing;
  int           m_cnt;
  logic [W-1:0] m_data;
  logic         m_pbit;
  logic [W-1:0] m_word;
  logic         m_vld, m_ovr, m_perr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      collecting <= 0; awaiting_par <= 0; capturing <= 0; m_cnt <= 0;
      m_data <= '0; m_pbit <= 0; m_word <= '0; m_vld <= 0; m_ovr <= 0; m_perr <= 0;
    end else if (capturing) begin
      capturing <= 0;
      if (!m_vld || word_rdy) begin
        m_word <= m_data;
        m_vld  <= 1;
`ifdef SR_SEQ_PARITY_EN
        m_perr <= (^m_data) ^ m_pbit;
`endif
      end else begin
        m_ovr <= 1;
      end
      if (start) begin collecting <= 1; m_cnt <= 0; end
    end else begin
      if (m_vld && word_rdy) m_vld <= 0;
      if (collecting) begin
        if (start) m_cnt <= 0;
        else if (din_vld) begin
          m_data <= {m_data[W-2:0], din};
          m_cnt  <= m_cnt + 1;
          if (m_cnt == W - 1) begin
            collecting <= 0;
`ifdef SR_SEQ_PARITY_EN
            awaiting_par <= 1;
`else
            capturing <= 1;
`endif
          end
        end
      end else if (awaiting_par) begin
        if (start) begin awaiting_par <= 0; collecting <= 1; m_cnt <= 0; end
        else if (din_vld) begin awaiting_par <= 0; capturing <= 1; m_pbit <= din; end
      end else if (start) begin
        collecting <= 1; m_cnt <= 0; m_ovr <= 0;
      end
    end
  end

  // Per-cycle compare against the model, plus event monitors
  bit chk_en = 0;
  int sr_en_cnt = 0;
  int rise_cnt = 0;
  logic vld_q = 0;

  always @(negedge clk) begin
    if (chk_en && rstn) begin
      check("sr_en",    32'(sr_en),    32'(collecting && din_vld && !start));
      check("sr_d",     32'(sr_d),     32'(din));
      check("busy",     32'(busy),     32'(collecting || awaiting_par || capturing));
      check("word_vld", 32'(word_vld), 32'(m_vld));
      check("word",     32'(word),     32'(m_word));
      check("overrun",  32'(overrun),  32'(m_ovr));
      check("par_err",  32'(par_err),  32'(m_perr));
    end
    if (sr_en) sr_en_cnt <= sr_en_cnt + 1;
    if (word_vld && !vld_q) rise_cnt <= rise_cnt + 1;
    vld_q <= word_vld;
  end

  task automatic step(input logic s, input logic d, input logic v);
    start = s; din = d; din_vld = v;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, w[i], 1'b1);
      if (gaps) step(1'b0, ~w[i], 1'b0);
    end
  endtask

  int c0;
  int r0;

  initial begin
    rstn = 1; start = 0; din = 0; din_vld = 0; word_rdy = 1;
    #3 rstn = 0;
    #1;
    check("rst_word_vld", 32'(word_vld), 32'h0);
    check("rst_word",     32'(word),     32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_overrun",  32'(overrun),  32'h0);
    check("rst_par_err",  32'(par_err),  32'h0);
    din_vld = 1;
    #1 check("rst_sr_en", 32'(sr_en), 32'h0);
    din_vld = 0;
    @(posedge clk); @(posedge clk); #4;
    rstn = 1;
    chk_en = 1;

    // Back-to-back frame 1,0,1,1,0,0,1,0
    step(1, 0, 0);
    c0 = sr_en_cnt;
    send_frame(8'hB2, 0);
    check("t1_vld_capture", 32'(word_vld), 32'h0);
    check("t1_busy_capture", 32'(busy), 32'h1);
    step(0, 0, 0);
    check("t1_vld", 32'(word_vld), 32'h1);
    check("t1_word", 32'(word), 32'hB2);
    check("t1_word_vs_sr", 32'(word), 32'(sr_out));
    check("t1_sr_en_count", 32'(sr_en_cnt - c0), 32'd8);
    step(0, 0, 0);
    check("t1_vld_fall", 32'(word_vld), 32'h0);

    // Same frame with strobe gaps
    step(1, 0, 0);
    c0 = sr_en_cnt;
    send_frame(8'hB2, 1);
    step(0, 0, 0);
    check("t2_word", 32'(word), 32'hB2);
    check("t2_sr_en_count", 32'(sr_en_cnt - c0), 32'd8);
    step(0, 0, 0);

    // Two frames with no consumer: second frame dropped
    word_rdy = 0;
    step(1, 0, 0); send_frame(8'h96, 0); step(0, 0, 0); step(0, 0, 0);
    check("t3_first_word", 32'(word), 32'h96);
    step(1, 0, 0); send_frame(8'h3C, 0); step(0, 0, 0); step(0, 0, 0);
    check("t3_held_word", 32'(word), 32'h96);
    check("t3_held_vld", 32'(word_vld), 32'h1);
    check("t3_overrun", 32'(overrun), 32'h1);
    step(1, 0, 0);
    check("t3_overrun_clr", 32'(overrun), 32'h0);
    word_rdy = 1;
    step(0, 0, 0);
    check("t3_drained", 32'(word_vld), 32'h0);

    // Abort after 5 bits, then a full new frame
    r0 = rise_cnt;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    step(1, 1, 1);
    send_frame(8'h5A, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    check("t4_word", 32'(word), 32'h5A);
    check("t4_one_word", 32'(rise_cnt - r0), 32'd1);

    // Asynchronous reset after 3 bits
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    start = 0; din = 1; din_vld = 1;
    rstn = 0;
    #1;
    check("t5_word", 32'(word), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_sr_en", 32'(sr_en), 32'h0);
    check("t5_vld", 32'(word_vld), 32'h0);
    #1 rstn = 1;
    step(0, 0, 0);
    step(1, 0, 0); send_frame(8'hC3, 0); step(0, 0, 0);
    check("t5_word_after", 32'(word), 32'hC3);
    check("t5_vld_after", 32'(word_vld), 32'h1);
    step(0, 0, 0);

`ifndef SR_SEQ_PARITY_EN
    // Minimum period: next start issued in the capture cycle
    r0 = rise_cnt;
    step(1, 0, 0); send_frame(8'h81, 0);
    step(1, 0, 0);
    check("t6_first", 32'(word), 32'h81);
    send_frame(8'h7E, 0);
    step(0, 0, 0);
    check("t6_second", 32'(word), 32'h7E);
    step(0, 0, 0);
    check("t6_two_words", 32'(rise_cnt - r0), 32'd2);
`else
    // Even parity on 0xA5: parity bit 0 is good, 1 is an error
    c0 = sr_en_cnt;
    step(1, 0, 0); send_frame(8'hA5, 0); step(0, 0, 1); step(0, 0, 0);
    check("t7_word", 32'(word), 32'hA5);
    check("t7_par_ok", 32'(par_err), 32'h0);
    check("t7_sr_en_count", 32'(sr_en_cnt - c0), 32'd8);
    step(0, 0, 0);
    c0 = sr_en_cnt;
    step(1, 0, 0); send_frame(8'hA5, 0); step(0, 1, 1); step(0, 0, 0);
    check("t7_par_bad", 32'(par_err), 32'h1);
    check("t7_sr_en_count2", 32'(sr_en_cnt - c0), 32'd8);
    step(0, 0, 0);
`endif

    step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
